// File: rtl/issue_scheduler_pkg.sv
// Shared micro-architecture types: uop encoding, op-subset vectors and the
// subset-membership helper used to route uops to execute pipes.
package issue_scheduler_pkg;

    localparam int unsigned OP_BITS  = 4;
    localparam int unsigned OP_COUNT = 16;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD  = 4'd0,
        OP_ADDI = 4'd1,
        OP_MUL  = 4'd2,
        OP_LW   = 4'd3,
        OP_SW   = 4'd4,
        OP_JAL  = 4'd5,
        OP_JR   = 4'd6,
        OP_BNE  = 4'd7
    } rv_op;

    // One bit per opcode; bit n set means the pipe executes opcode n.
    typedef logic [OP_COUNT-1:0] rv_op_vec;

    typedef struct packed {
        rv_op       op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } rv_uop;

    localparam rv_op_vec OP_ADD_VEC  = 16'h0001;
    localparam rv_op_vec OP_ADDI_VEC = 16'h0002;
    localparam rv_op_vec OP_MUL_VEC  = 16'h0004;
    localparam rv_op_vec OP_LW_VEC   = 16'h0008;
    localparam rv_op_vec OP_SW_VEC   = 16'h0010;
    localparam rv_op_vec OP_JAL_VEC  = 16'h0020;
    localparam rv_op_vec OP_JR_VEC   = 16'h0040;
    localparam rv_op_vec OP_BNE_VEC  = 16'h0080;

    localparam rv_op_vec OP_ALU_VEC = OP_ADD_VEC | OP_ADDI_VEC | OP_JAL_VEC | OP_JR_VEC | OP_BNE_VEC;

    // Full TinyRV1 op set: the default capability of every pipe.
    localparam rv_op_vec p_tinyrv1 = OP_ALU_VEC | OP_MUL_VEC | OP_LW_VEC | OP_SW_VEC;

    // True when the uop's opcode is in the given pipe capability set.
    function automatic logic op_in_subset(rv_op_vec subset, rv_uop uop);
        return subset[uop.op];
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode-to-scheduler and scheduler-to-pipes handshake bundle.
// master: environment side (decode drives in_*, pipes drive ex_rdy).
// slave:  the scheduler.
interface issue_scheduler_if #(
    parameter int unsigned p_num_pipes    = 3,
    parameter int unsigned p_payload_bits = 32
) ();
    import issue_scheduler_pkg::*;

    rv_uop                     in_uop;
    logic [p_payload_bits-1:0] in_payload;
    logic                      in_val;
    logic                      in_rdy;
    logic [p_num_pipes-1:0]    ex_val;
    logic [p_num_pipes-1:0]    ex_rdy;
    rv_uop                     ex_uop;
    logic [p_payload_bits-1:0] ex_payload;

    modport master (
        output in_uop, in_payload, in_val, ex_rdy,
        input  in_rdy, ex_val, ex_uop, ex_payload
    );

    modport slave (
        input  in_uop, in_payload, in_val, ex_rdy,
        output in_rdy, ex_val, ex_uop, ex_payload
    );

endinterface

// File: rtl/issue_fifo.sv
// In-order uop queue: power-of-two depth, wrapping pointers, synchronous
// flush to empty, head word visible combinationally.
module issue_fifo #(
    parameter int unsigned p_depth = 4,
    parameter int unsigned p_width = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [p_width-1:0]       wdata,
    output logic [p_width-1:0]       rdata_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(p_depth):0] count
);

    localparam int unsigned AW = $clog2(p_depth);
    localparam int unsigned CW = AW + 1;

    logic [p_width-1:0] mem [p_depth];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic               do_push;
    logic               do_pop;

    assign full_c  = (count == CW'(p_depth));
    assign empty_c = (count == '0);
    assign rdata_c = mem[rd_ptr];
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;

    // Pointer and occupancy tracking; flush returns to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; data needs no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Buffered issue scheduler: queues decoded uops and dispatches the head to
// one capable execute pipe per transfer.
// Build option ISSUE_RR_EN: when defined, the pipe scan starts at a
// round-robin pointer; otherwise it always starts at pipe 0.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned                  p_num_pipes    = 3,
    parameter rv_op_vec [p_num_pipes-1:0]   p_pipe_subsets = {p_num_pipes{p_tinyrv1}},
    parameter int unsigned                  p_depth        = 4,
    parameter int unsigned                  p_payload_bits = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    issue_scheduler_if.slave     bus,
    output logic [15:0]          stall_cnt,
    output logic                 unsup
);

    localparam int unsigned PW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
    localparam int unsigned UW = $bits(rv_uop);
    localparam int unsigned EW = UW + p_payload_bits;
    localparam int unsigned CW = $clog2(p_depth) + 1;

    logic [EW-1:0]          head_c;
    rv_uop                  head_uop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic                   push_c;
    logic                   pop_c;

    logic [p_num_pipes-1:0] eligible_c;
    logic [p_num_pipes-1:0] ex_val_c;
    logic [PW-1:0]          start_c;
    logic [PW-1:0]          sel_c;
    logic [PW-1:0]          sel_rdy_c;
    logic [PW-1:0]          sel_elig_c;
    logic [PW-1:0]          scan_idx_c;
    int unsigned            scan_sum_c;
    logic                   hit_rdy_c;
    logic                   hit_elig_c;
    logic                   xfer_c;
    logic                   drop_c;
    logic                   stall_c;

    issue_fifo #(
        .p_depth (p_depth),
        .p_width (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   ({bus.in_uop, bus.in_payload}),
        .rdata_c (head_c),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .count   (fifo_count)
    );

    assign head_uop       = rv_uop'(head_c[EW-1 -: UW]);
    assign bus.ex_uop     = head_uop;
    assign bus.ex_payload = head_c[p_payload_bits-1:0];
    assign bus.in_rdy     = !fifo_full;
    assign bus.ex_val     = ex_val_c;

    // Accept from decode only when there is room; flush discards it anyway.
    assign push_c = bus.in_val && !fifo_full && !flush;
    // Head leaves on a transfer, or is dropped when no pipe can execute it.
    assign pop_c  = (xfer_c || drop_c) && !flush;

    // A pipe is eligible when the queue has a head it is able to execute.
    for (genvar gi = 0; gi < p_num_pipes; gi++) begin : g_elig
        assign eligible_c[gi] = !fifo_empty && op_in_subset(p_pipe_subsets[gi], head_uop);
    end

    // Scan from start: prefer the first eligible+ready pipe, else first eligible.
    always_comb begin
        sel_rdy_c  = '0;
        sel_elig_c = '0;
        hit_rdy_c  = 1'b0;
        hit_elig_c = 1'b0;
        scan_idx_c = '0;
        scan_sum_c = '0;
        for (int unsigned k = 0; k < p_num_pipes; k++) begin
            scan_sum_c = 32'(start_c) + k;
            if (scan_sum_c >= p_num_pipes) scan_sum_c = scan_sum_c - p_num_pipes;
            scan_idx_c = PW'(scan_sum_c);
            if (!hit_rdy_c && eligible_c[scan_idx_c] && bus.ex_rdy[scan_idx_c]) begin
                hit_rdy_c = 1'b1;
                sel_rdy_c = scan_idx_c;
            end
            if (!hit_elig_c && eligible_c[scan_idx_c]) begin
                hit_elig_c = 1'b1;
                sel_elig_c = scan_idx_c;
            end
        end
        sel_c = hit_rdy_c ? sel_rdy_c : sel_elig_c;
    end

    // One-hot valid toward the selected pipe, none when nothing is eligible.
    always_comb begin
        ex_val_c = '0;
        if (hit_elig_c) ex_val_c[sel_c] = 1'b1;
    end

    assign xfer_c  = |(ex_val_c & bus.ex_rdy);
    assign drop_c  = !fifo_empty && !(|eligible_c);
    assign stall_c = (|eligible_c) && !xfer_c;

`ifdef ISSUE_RR_EN
    logic [PW-1:0] rr;
    logic [PW-1:0] rr_next_c;

    assign rr_next_c = (sel_c == PW'(p_num_pipes - 1)) ? '0 : sel_c + PW'(1);
    assign start_c   = rr;

    // Advance the round-robin pointer past the pipe that just took a uop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rr <= '0;
        else if (xfer_c && !flush) rr <= rr_next_c;
    end
`else
    assign start_c = '0;
`endif

    // Saturating count of cycles where the head waits on a capable pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         stall_cnt <= '0;
        else if (!flush && stall_c && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end

    // Sticky flag: some uop matched no pipe since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                unsup <= 1'b0;
        else if (!flush && drop_c) unsup <= 1'b1;
    end

    // Occupancy can never exceed the configured depth.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CW'(p_depth));

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios plus a
// randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    localparam int unsigned NP    = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PB    = 32;
    // pipe0/pipe2: ALU ops; pipe1: ALU ops plus MUL; nobody runs LW/SW.
    localparam rv_op_vec [NP-1:0] SUBSETS = {OP_ALU_VEC, OP_ALU_VEC | OP_MUL_VEC, OP_ALU_VEC};
`ifdef ISSUE_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct packed {
        rv_uop          uop;
        logic [PB-1:0]  pl;
    } ent_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] stall_cnt;
    logic        unsup;
    int          total = 0;
    int          bad   = 0;

    issue_scheduler_if #(.p_num_pipes(NP), .p_payload_bits(PB)) bus ();

    issue_scheduler #(
        .p_num_pipes    (NP),
        .p_pipe_subsets (SUBSETS),
        .p_depth        (DEPTH),
        .p_payload_bits (PB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .unsup     (unsup)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic rv_uop mk(rv_op op, logic [4:0] rd);
        rv_uop u;
        u.op = op; u.rd = rd; u.rs1 = 5'd1; u.rs2 = 5'd2;
        return u;
    endfunction

    task automatic idle();
        bus.in_val = 1'b0; bus.in_uop = '0; bus.in_payload = '0; bus.ex_rdy = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic offer(rv_op op, logic [31:0] pl);
        bus.in_val = 1'b1; bus.in_uop = mk(op, pl[4:0]); bus.in_payload = pl;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL rst_ex_val: got %b want 000", bus.ex_val); end
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL rst_in_rdy: got %b want 1", bus.in_rdy); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
        total++; if (unsup !== 1'b0) begin bad++; $display("FAIL rst_unsup: got %b want 0", unsup); end
        step();
        for (int i = 0; i < 3; i++) begin offer(OP_ADD, 32'h10 + 32'(i)); step(); end
        bus.in_val = 1'b0; step(); step();
        @(negedge clk);
        total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL pre_rst_stall: got %0d want 4", stall_cnt); end
        rst_n = 1'b0; #1;
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL async_rst_ex_val: got %b want 000", bus.ex_val); end
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL async_rst_in_rdy: got %b want 1", bus.in_rdy); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL async_rst_stall: got %0d want 0", stall_cnt); end
        @(posedge clk); #1 rst_n = 1'b1;
        bus.ex_rdy = '1; offer(OP_ADD, 32'hA5);
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL no_bypass: got %b want 000", bus.ex_val); end
        step(); bus.in_val = 1'b0;
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b001) begin bad++; $display("FAIL first_issue: got %b want 001", bus.ex_val); end
        total++; if (bus.ex_payload !== 32'hA5) begin bad++; $display("FAIL first_payload: got %h want a5", bus.ex_payload); end
        step();
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL after_issue: got %b want 000", bus.ex_val); end
        step();
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] gv[$];
        logic [31:0]   gp[$];
        logic [NP-1:0] ev;
        do_reset();
        bus.ex_rdy = '1;
        for (int c = 0; c < 12; c++) begin
            if (c < 6) offer(OP_ADD, 32'h100 + 32'(c)); else bus.in_val = 1'b0;
            @(negedge clk);
            if (bus.ex_val !== '0) begin gv.push_back(bus.ex_val); gp.push_back(bus.ex_payload); end
            step();
        end
        total++; if (gv.size() != 6) begin bad++; $display("FAIL rr_count: got %0d want 6", gv.size()); end
        for (int i = 0; i < 6; i++) begin
            ev = RR_EN ? NP'(3'b001 << (i % 3)) : NP'(3'b001);
            if (i < gv.size()) begin
                total++; if (gv[i] !== ev) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", i, gv[i], ev); end
                total++; if (gp[i] !== 32'h100 + 32'(i)) begin bad++; $display("FAIL rr_payload%0d: got %h want %h", i, gp[i], 32'h100 + 32'(i)); end
            end
        end
    endtask

    task automatic test_routing();
        do_reset();
        bus.ex_rdy = 3'b101; offer(OP_MUL, 32'h200);
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL route_empty: got %b want 000", bus.ex_val); end
        step(); bus.in_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (bus.ex_val !== 3'b010) begin bad++; $display("FAIL route_val%0d: got %b want 010", k, bus.ex_val); end
            total++; if (stall_cnt !== 16'(k)) begin bad++; $display("FAIL route_stall%0d: got %0d want %0d", k, stall_cnt, k); end
            step();
        end
        bus.ex_rdy = 3'b111;
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b010) begin bad++; $display("FAIL route_issue: got %b want 010", bus.ex_val); end
        total++; if (bus.ex_payload !== 32'h200) begin bad++; $display("FAIL route_payload: got %h want 200", bus.ex_payload); end
        step(); bus.ex_rdy = 3'b101;
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL route_done: got %b want 000", bus.ex_val); end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL route_stall_final: got %0d want 3", stall_cnt); end
        step();
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            offer(OP_ADD, 32'h300 + 32'(c));
            @(negedge clk);
            total++; if (bus.in_rdy !== (c < 4)) begin bad++; $display("FAIL full_in_rdy%0d: got %b want %b", c, bus.in_rdy, (c < 4)); end
            step();
        end
        bus.ex_rdy = 3'b111;
        @(negedge clk);
        total++; if (bus.in_rdy !== 1'b0) begin bad++; $display("FAIL full_no_passthru: got %b want 0", bus.in_rdy); end
        total++; if (bus.ex_val !== 3'b001) begin bad++; $display("FAIL full_xfer_val: got %b want 001", bus.ex_val); end
        total++; if (bus.ex_payload !== 32'h300) begin bad++; $display("FAIL full_xfer_payload: got %h want 300", bus.ex_payload); end
        step(); bus.ex_rdy = 3'b000;
        @(negedge clk);
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL full_freed: got %b want 1", bus.in_rdy); end
        step(); bus.in_val = 1'b0;
        @(negedge clk);
        total++; if (bus.in_rdy !== 1'b0) begin bad++; $display("FAIL full_again: got %b want 0", bus.in_rdy); end
        step(); bus.ex_rdy = 3'b111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if ($countones(bus.ex_val) != 1) begin bad++; $display("FAIL drain_val%0d: got %b want one-hot", i, bus.ex_val); end
            total++; if (bus.ex_payload !== 32'h301 + 32'(i)) begin bad++; $display("FAIL drain_payload%0d: got %h want %h", i, bus.ex_payload, 32'h301 + 32'(i)); end
            step();
        end
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL drain_empty: got %b want 000", bus.ex_val); end
        step();
    endtask

    task automatic test_unsup();
        do_reset();
        bus.ex_rdy = 3'b111; offer(OP_SW, 32'h400);
        @(negedge clk); step();
        offer(OP_ADD, 32'h401);
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL unsup_no_val: got %b want 000", bus.ex_val); end
        total++; if (unsup !== 1'b0) begin bad++; $display("FAIL unsup_early: got %b want 0", unsup); end
        step(); bus.in_val = 1'b0;
        @(negedge clk);
        total++; if (unsup !== 1'b1) begin bad++; $display("FAIL unsup_set: got %b want 1", unsup); end
        total++; if (bus.ex_val !== 3'b001) begin bad++; $display("FAIL unsup_next_val: got %b want 001", bus.ex_val); end
        total++; if (bus.ex_payload !== 32'h401) begin bad++; $display("FAIL unsup_next_payload: got %h want 401", bus.ex_payload); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL unsup_stall: got %0d want 0", stall_cnt); end
        step();
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL unsup_drained: got %b want 000", bus.ex_val); end
        total++; if (unsup !== 1'b1) begin bad++; $display("FAIL unsup_sticky: got %b want 1", unsup); end
        step();
    endtask

    task automatic test_flush();
        logic [NP-1:0] ev;
        do_reset();
        bus.ex_rdy = 3'b111; offer(OP_ADD, 32'h500); step();
        bus.in_val = 1'b0; step();
        bus.ex_rdy = 3'b000;
        for (int i = 1; i <= 3; i++) begin offer(OP_ADD, 32'h500 + 32'(i)); step(); end
        flush = 1'b1; offer(OP_ADD, 32'h504);
        ev = RR_EN ? NP'(3'b010) : NP'(3'b001);
        @(negedge clk);
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL flush_pre_stall: got %0d want 2", stall_cnt); end
        total++; if (bus.ex_val !== ev) begin bad++; $display("FAIL flush_pre_val: got %b want %b", bus.ex_val, ev); end
        step(); flush = 1'b0;
        bus.ex_rdy = 3'b111; offer(OP_ADD, 32'h505);
        @(negedge clk);
        total++; if (bus.ex_val !== 3'b000) begin bad++; $display("FAIL flush_empty: got %b want 000", bus.ex_val); end
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL flush_in_rdy: got %b want 1", bus.in_rdy); end
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL flush_stall_kept: got %0d want 2", stall_cnt); end
        step(); bus.in_val = 1'b0;
        @(negedge clk);
        total++; if (bus.ex_val !== ev) begin bad++; $display("FAIL flush_rr_kept: got %b want %b", bus.ex_val, ev); end
        total++; if (bus.ex_payload !== 32'h505) begin bad++; $display("FAIL flush_payload: got %h want 505", bus.ex_payload); end
        step();
    endtask

    task automatic test_random();
        ent_t          q[$];
        int            rr;
        int            stall;
        bit            uns;
        bit            el[NP];
        bit            any_el;
        bit            xfer;
        bit            drop;
        bit            accept;
        int            sel;
        int            start;
        int            p;
        int unsigned   r;
        rv_op          op;
        logic [NP-1:0] ev;
        rr = 0; stall = 0; uns = 1'b0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 15);
            op = (r < 6) ? OP_ADD : (r < 9) ? OP_ADDI : (r < 12) ? OP_MUL : (r < 14) ? OP_BNE : (r == 14) ? OP_SW : OP_LW;
            if ($urandom_range(0, 3) != 0) offer(op, $urandom); else bus.in_val = 1'b0;
            flush = ($urandom_range(0, 39) == 0);
            bus.ex_rdy = (c < 300) ? NP'($urandom & $urandom) : NP'($urandom);
            // reference: scan pipes from the pointer per the selection rules
            any_el = 1'b0; sel = -1;
            for (int i = 0; i < NP; i++) begin
                el[i] = (q.size() > 0) ? SUBSETS[i][q[0].uop.op] : 1'b0;
                any_el = any_el | el[i];
            end
            start = RR_EN ? rr : 0;
            for (int k = 0; k < NP; k++) begin p = (start + k) % NP; if (sel < 0 && el[p] && bus.ex_rdy[p]) sel = p; end
            for (int k = 0; k < NP; k++) begin p = (start + k) % NP; if (sel < 0 && el[p]) sel = p; end
            ev = (sel >= 0) ? NP'(1 << sel) : '0;
            @(negedge clk);
            total++; if (bus.in_rdy !== (q.size() < DEPTH)) begin bad++; $display("FAIL rnd_in_rdy c%0d: got %b want %b", c, bus.in_rdy, (q.size() < DEPTH)); end
            total++; if (bus.ex_val !== ev) begin bad++; $display("FAIL rnd_ex_val c%0d: got %b want %b", c, bus.ex_val, ev); end
            total++; if (stall_cnt !== 16'(stall)) begin bad++; $display("FAIL rnd_stall c%0d: got %0d want %0d", c, stall_cnt, stall); end
            total++; if (unsup !== uns) begin bad++; $display("FAIL rnd_unsup c%0d: got %b want %b", c, unsup, uns); end
            if (q.size() > 0) begin
                total++; if (bus.ex_payload !== q[0].pl) begin bad++; $display("FAIL rnd_payload c%0d: got %h want %h", c, bus.ex_payload, q[0].pl); end
                total++; if (bus.ex_uop !== q[0].uop) begin bad++; $display("FAIL rnd_uop c%0d: got %h want %h", c, bus.ex_uop, q[0].uop); end
            end
            xfer   = (sel >= 0) && bus.ex_rdy[sel];
            drop   = (q.size() > 0) && !any_el;
            accept = bus.in_val && (q.size() < DEPTH) && !flush;
            if (flush) q.delete();
            else begin
                if (xfer || drop) void'(q.pop_front());
                if (accept) q.push_back('{uop: bus.in_uop, pl: bus.in_payload});
                if (xfer) rr = (sel + 1) % NP;
                if (any_el && !xfer && stall < 65535) stall++;
                if (drop) uns = 1'b1;
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_round_robin();
        test_routing();
        test_full();
        test_unsup();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Buffered issue scheduler between the decode stage and the execute pipes. It holds decoded uops in a small in-order queue and dispatches the queue head to exactly one capable pipe per transfer. When several capable pipes are ready, it picks one by round-robin, so identical pipes share load fairly instead of always favouring the lowest index. It also reports stall cycles and unsupported uops for debug.

## Interface
- p_num_pipes, 3, number of execute pipes
- p_pipe_subsets, '{default: p_tinyrv1}, rv_op_vec per pipe: the ops that pipe executes
- p_depth, 4, queue entries; power of two, ≥2
- p_payload_bits, 32, opaque per-uop payload (operands/tags) forwarded with the uop
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard all queued uops
- in_uop  in  rv_uop  uop from decode
- in_payload  in  p_payload_bits  payload from decode
- in_val  in  1  decode offers a uop
- in_rdy  out  1  scheduler accepts (= !full)
- ex_val  out  p_num_pipes  one-hot-or-zero issue valid per pipe
- ex_rdy  in  p_num_pipes  pipe ready
- ex_uop  out  rv_uop  head uop, broadcast to all pipes
- ex_payload  out  p_payload_bits  head payload, broadcast to all pipes
- stall_cnt  out  16  saturating count of head-blocked cycles
- unsup  out  1  sticky: a uop matched no pipe

## Operation
- Enqueue when in_val & in_rdy & !flush. The queue is in order, with count, rd_ptr and wr_ptr wrapping mod p_depth.
- eligible[i] = (head uop ∈ p_pipe_subsets[i]) & !empty.
- Selection starts at pointer rr and scans indices rr, rr+1, … mod p_num_pipes:
  - sel = the first index with eligible & ex_rdy;
  - if no such index exists, sel = the first eligible index.
- ex_val[sel] = 1 and all other bits are 0. ex_val may depend combinationally on ex_rdy.
- Issue xfer = ex_val[sel] & ex_rdy[sel]. On xfer, pop the head and set rr ← (sel+1) mod p_num_pipes.
- Head not empty with no eligible pipe:
  - set unsup;
  - pop the head in that cycle, with no ex_val raised;
  - leave rr unchanged.
- stall_cnt increments when the head is not empty, eligible is nonzero and there is no xfer. It saturates at 16'hFFFF.
- flush:
  - the next state is empty;
  - the same-cycle enqueue and xfer are still signalled to neighbours but have no effect on the queue;
  - rr, stall_cnt and unsup are preserved.
- unsup clears only on reset.

## Timing
- Reset (async assert, clk-synchronous deassert use): queue empty, rr=0, stall_cnt=0, unsup=0. Resulting outputs: ex_val=0, in_rdy=1.
- Latency: a uop accepted in cycle t can issue in cycle t+1 at the earliest. There is no bypass.
- Throughput: 1 uop/cycle sustained.
- Full: in_rdy=0 even if an xfer happens in the same cycle (no full pass-through).
- Empty: ex_val=0; ex_uop/ex_payload are don't-care.
- Simultaneous enqueue and pop when neither full nor empty: count is unchanged and both pointers advance.
- Reset mid-operation discards all entries immediately (async).

## Configuration
- ISSUE_RR_EN defined: round-robin selection as above.
- ISSUE_RR_EN undefined: no rr register; the scan always starts at index 0 (fixed lowest-index priority). All other behaviour is identical.

## Structure
- The subset-membership function op_in_subset(rv_op_vec, rv_uop) lives in the shared UArch package, beside rv_uop and the OP_*_VEC constants.
- Queue storage and pointers go in sub-module issue_fifo (parameterised depth/width, exposing full/empty/count). The scheduler holds the selection, rr, counters and flags.

## Test plan
- Reset: hold rst_n=0 mid-stream with 3 queued uops → ex_val=0, in_rdy=1, stall_cnt=0 immediately; after release, the first new uop issues one cycle after enqueue.
- Round-robin: 3 pipes all supporting OP_ADD, all ready, 6 back-to-back ADDs → grants to pipes 0,1,2,0,1,2; with ISSUE_RR_EN undefined → 0,0,0,0,0,0.
- Routing: pipe1 only MUL, pipe0/2 ALU; MUL with ex_rdy=3'b101 → ex_val=3'b010, no xfer, stall_cnt increments each cycle; ex_rdy[1]=1 → issues to pipe 1.
- Full: ex_rdy=0, enqueue 4 uops (p_depth=4) → in_rdy=0 on cycle 5; one xfer frees an entry → in_rdy=1 the following cycle.
- Unsupported: OP_SW when no pipe supports SW → unsup=1 and the entry is dropped in one cycle; the following ADD issues normally; unsup stays 1.
- Flush: 3 queued, flush with in_val=1 → next cycle empty, ex_val=0; stall_cnt and rr are unchanged.
